display_scan_controller: RTL and testbench

Time-multiplexed 7-segment display scheduler for the clock.
- Shares one cathode bus among six digits: hours, minutes and seconds, two digits each.
- Converts the 6-bit binary time fields into tens and ones digits.
- Blinks the field currently being adjusted, as selected by modo_ajuste from the adjust controller.
- Sits between the timekeeping/adjust logic and the board's anode/cathode pins.

---
 rtl/display_scan_controller.sv | 153 +++++++++++++++
 tb/tb_display_scan_controller.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Six-digit HH:MM:SS 7-segment scan driver with blinking of the field under adjust.
// Define COLON_DP_EN to light the dp on idx2/idx4 as hour/minute/second separators.
module display_scan_controller #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk_100MHz,
  input  logic       rstn,
  input  logic [5:0] segundos,
  input  logic [5:0] minutos,
  input  logic [5:0] horas,
  input  logic [1:0] modo_ajuste,
  output logic [7:0] an,
  output logic [7:0] dec_cat
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [SCAN_W-1:0]  scan_cnt_q,    scan_cnt_d;
  logic [2:0]         idx_q,         idx_d;
  logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [1:0]         modo_prev_q,   modo_prev_d;
  logic [7:0]         an_q,          an_d;
  logic [7:0]         dec_cat_q,     dec_cat_d;

  logic       mode_chg;
  logic       phase_eff;
  logic [5:0] field;
  logic       over;
  logic [7:0] bcd;
  logic [3:0] digit;
  logic [6:0] seg;
  logic       blank;
  logic       dp_n;

  // Comparison ladder instead of a divider; values >=60 are dashed by the caller.
  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    if (v >= 6'd50) begin
      tens = 4'd5; ones = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      tens = 4'd4; ones = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      tens = 4'd3; ones = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      tens = 4'd2; ones = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      tens = 4'd1; ones = 4'(v - 6'd10);
    end else begin
      tens = 4'd0; ones = v[3:0];
    end
    return {tens, ones};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    // A mode change forces phase 0 this very cycle so the new field shows at once.
    mode_chg  = (modo_ajuste != modo_prev_q);
    phase_eff = blink_phase_q & ~mode_chg;

    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end

    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (mode_chg) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    modo_prev_d = modo_ajuste;

    case (idx_q[2:1])
      2'd0:    field = segundos;
      2'd1:    field = minutos;
      default: field = horas;
    endcase
    over  = idx_q[2] ? (field > 6'd23) : (field > 6'd59);
    bcd   = bin2bcd(field);
    digit = idx_q[0] ? bcd[7:4] : bcd[3:0];
    seg   = over ? SEG_DASH : seg7(digit);

    // modo_ajuste encodes the field as idx/2 + 1 (01 sec, 10 min, 11 hours).
    blank = (modo_ajuste != 2'b00) && phase_eff && (modo_ajuste == (idx_q[2:1] + 2'd1));

`ifdef COLON_DP_EN
    dp_n = ~(((idx_q == 3'd2) || (idx_q == 3'd4)) && ((modo_ajuste != 2'b00) || !phase_eff));
`else
    dp_n = 1'b1;
`endif

    an_d      = 8'hFF;
    dec_cat_d = 8'hFF;
    if ((idx_q < 3'd6) && !blank) begin
      an_d[idx_q] = 1'b0;
      dec_cat_d   = {dp_n, seg};
    end
  end

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      scan_cnt_q    <= '0;
      idx_q         <= 3'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      modo_prev_q   <= 2'b00;
      an_q          <= 8'hFF;
      dec_cat_q     <= 8'hFF;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      modo_prev_q   <= modo_prev_d;
      an_q          <= an_d;
      dec_cat_q     <= dec_cat_d;
    end
  end

  assign an      = an_q;
  assign dec_cat = dec_cat_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with SCAN_DIV=4, BLINK_DIV=16; a cycle model pushes
// the expected registered outputs to a scoreboard queue that each test pops and checks.
`timescale 1ns/1ps
module tb_display_scan_controller;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [5:0] segundos = 6'd0;
  logic [5:0] minutos = 6'd0;
  logic [5:0] horas = 6'd0;
  logic [1:0] modo_ajuste = 2'b00;
  logic [7:0] an;
  logic [7:0] dec_cat;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] cat;
  } exp_t;

  exp_t sb_q[$];
  int   m_scan, m_idx, m_blink;
  logic m_phase;
  logic [1:0] m_prev;

  logic [7:0] an_tbl  [6] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};
  logic [6:0] seg_tbl [6] = '{7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  display_scan_controller #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk_100MHz (clk),
    .rstn       (rstn),
    .segundos   (segundos),
    .minutos    (minutos),
    .horas      (horas),
    .modo_ajuste(modo_ajuste),
    .an         (an),
    .dec_cat    (dec_cat)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   val, lim;
    logic ph, blank;
    ph    = (modo_ajuste != m_prev) ? 1'b0 : m_phase;
    e.an  = 8'hFF;
    e.cat = 8'hFF;
    val   = (m_idx < 2) ? int'(segundos) : (m_idx < 4) ? int'(minutos) : int'(horas);
    lim   = (m_idx >= 4) ? 23 : 59;
    blank = (modo_ajuste != 2'b00) && ph && (int'(modo_ajuste) == m_idx / 2 + 1);
    if (!blank) begin
      e.an[m_idx] = 1'b0;
      if (val > lim) e.cat[6:0] = 7'b0111111;
      else e.cat[6:0] = seg_code((m_idx % 2 == 0) ? val % 10 : val / 10);
`ifdef COLON_DP_EN
      if ((m_idx == 2 || m_idx == 4) && (modo_ajuste != 2'b00 || ph == 1'b0)) e.cat[7] = 1'b0;
`endif
    end
    return e;
  endfunction

  task automatic model_reset();
    m_scan = 0; m_idx = 0; m_blink = 0; m_phase = 1'b0; m_prev = 2'b00;
    sb_q.delete();
  endtask

  task automatic model_push();
    logic chg;
    chg = (modo_ajuste != m_prev);
    sb_q.push_back(model_out());
    if (m_scan == SCAN_DIV - 1) begin
      m_scan = 0;
      m_idx  = (m_idx == 5) ? 0 : m_idx + 1;
    end else m_scan++;
    if (chg) begin
      m_blink = 0; m_phase = 1'b0;
    end else if (m_blink == BLINK_DIV - 1) begin
      m_blink = 0; m_phase = ~m_phase;
    end else m_blink++;
    m_prev = modo_ajuste;
  endtask

  task automatic run_cycle(output exp_t e, output int idx);
    idx = m_idx;
    model_push();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (an !== 8'hFF) begin failures++; $display("FAIL reset_an got=%h want=FF", an); end
    checks++;
    if (dec_cat !== 8'hFF) begin failures++; $display("FAIL reset_cat got=%h want=FF", dec_cat); end
    horas = 6'd12; minutos = 6'd34; segundos = 6'd56; modo_ajuste = 2'b00;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_scan();
    exp_t e; int idx;
    for (int i = 0; i < 24; i++) begin
      run_cycle(e, idx);
      checks++;
      if (an !== an_tbl[i / 4]) begin
        failures++; $display("FAIL scan_an cyc=%0d got=%h want=%h", i, an, an_tbl[i / 4]);
      end
      checks++;
      if (dec_cat[6:0] !== seg_tbl[i / 4]) begin
        failures++; $display("FAIL scan_seg cyc=%0d got=%b want=%b", i, dec_cat[6:0], seg_tbl[i / 4]);
      end
      checks++;
      if ({an, dec_cat} !== {e.an, e.cat}) begin
        failures++; $display("FAIL scan_sb cyc=%0d got=%h/%h want=%h/%h", i, an, dec_cat, e.an, e.cat);
      end
    end
  endtask

  task automatic test_blink();
    exp_t e; int idx; int blanks; bit found;
    blanks = 0; found = 1'b0;
    modo_ajuste = 2'b10;
    for (int i = 0; i < 64; i++) begin
      run_cycle(e, idx);
      if (an === 8'hFF) blanks++;
      checks++;
      if ({an, dec_cat} !== {e.an, e.cat}) begin
        failures++; $display("FAIL blink_sb cyc=%0d idx=%0d got=%h/%h want=%h/%h", i, idx, an, dec_cat, e.an, e.cat);
      end
    end
    checks++;
    if (blanks == 0) begin failures++; $display("FAIL blink_seen got=%0d want=>0", blanks); end
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_phase == 1'b1 && m_idx == 4) begin
        found = 1'b1;
        modo_ajuste = 2'b11;
      end
      run_cycle(e, idx);
      checks++;
      if ({an, dec_cat} !== {e.an, e.cat}) begin
        failures++; $display("FAIL blink_wait_sb idx=%0d got=%h/%h want=%h/%h", idx, an, dec_cat, e.an, e.cat);
      end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL blink_switch_timeout got=0 want=1"); end
    checks++;
    if (an !== 8'hEF || dec_cat[6:0] !== 7'b0100100) begin
      failures++; $display("FAIL mode_switch_visible got=%h/%b want=EF/0100100", an, dec_cat[6:0]);
    end
    for (int i = 0; i < 40; i++) begin
      run_cycle(e, idx);
      checks++;
      if ({an, dec_cat} !== {e.an, e.cat}) begin
        failures++; $display("FAIL blink_restart_sb cyc=%0d got=%h/%h want=%h/%h", i, an, dec_cat, e.an, e.cat);
      end
    end
  endtask

  task automatic test_dash();
    exp_t e; int idx; logic [6:0] want;
    modo_ajuste = 2'b00; segundos = 6'd63; horas = 6'd24; minutos = 6'd34;
    for (int i = 0; i < 24; i++) begin
      run_cycle(e, idx);
      want = (idx == 2) ? 7'b0011001 : (idx == 3) ? 7'b0110000 : 7'b0111111;
      checks++;
      if (dec_cat[6:0] !== want || an !== an_tbl[idx]) begin
        failures++; $display("FAIL dash idx=%0d got=%h/%b want=%h/%b", idx, an, dec_cat[6:0], an_tbl[idx], want);
      end
      checks++;
      if ({an, dec_cat} !== {e.an, e.cat}) begin
        failures++; $display("FAIL dash_sb idx=%0d got=%h/%h want=%h/%h", idx, an, dec_cat, e.an, e.cat);
      end
    end
  endtask

  task automatic test_step();
    exp_t e; int idx; bit found;
    found = 1'b0;
    segundos = 6'd59; minutos = 6'd34; horas = 6'd12; modo_ajuste = 2'b00;
    for (int i = 0; i < 100 && !found; i++) begin
      run_cycle(e, idx);
      checks++;
      if ({an, dec_cat} !== {e.an, e.cat}) begin
        failures++; $display("FAIL step_sb got=%h/%h want=%h/%h", an, dec_cat, e.an, e.cat);
      end
      if (m_idx == 1 && m_scan == 2) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL step_timeout got=0 want=1"); end
    checks++;
    if (an !== 8'hFD || dec_cat[6:0] !== 7'b0010010) begin
      failures++; $display("FAIL step_before got=%h/%b want=FD/0010010", an, dec_cat[6:0]);
    end
    segundos = 6'd0;
    for (int i = 0; i < 2; i++) begin
      run_cycle(e, idx);
      checks++;
      if (an !== 8'hFD || dec_cat[6:0] !== 7'b1000000) begin
        failures++; $display("FAIL step_after cyc=%0d got=%h/%b want=FD/1000000", i, an, dec_cat[6:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; int idx; bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      run_cycle(e, idx);
      if (m_idx == 3 && m_scan == 1) found = 1'b1;
    end
    checks++;
    if (!found || an !== 8'hF7) begin
      failures++; $display("FAIL rst_mid_pre got=%h want=F7", an);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (an !== 8'hFF || dec_cat !== 8'hFF) begin
      failures++; $display("FAIL rst_mid_async got=%h/%h want=FF/FF", an, dec_cat);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      run_cycle(e, idx);
      checks++;
      if (an !== an_tbl[i / 4]) begin
        failures++; $display("FAIL rst_mid_restart cyc=%0d got=%h want=%h", i, an, an_tbl[i / 4]);
      end
      checks++;
      if ({an, dec_cat} !== {e.an, e.cat}) begin
        failures++; $display("FAIL rst_mid_sb cyc=%0d got=%h/%h want=%h/%h", i, an, dec_cat, e.an, e.cat);
      end
    end
  endtask

  task automatic test_dp();
    exp_t e; int idx; int dp_lo, dp_hi;
    dp_lo = 0; dp_hi = 0;
    segundos = 6'd56; minutos = 6'd34; horas = 6'd12; modo_ajuste = 2'b00;
    for (int i = 0; i < 64; i++) begin
      run_cycle(e, idx);
      checks++;
      if ({an, dec_cat} !== {e.an, e.cat}) begin
        failures++; $display("FAIL dp_norm_sb idx=%0d got=%h/%h want=%h/%h", idx, an, dec_cat, e.an, e.cat);
      end
      if (idx == 2 || idx == 4) begin
        if (dec_cat[7] === 1'b0) dp_lo++; else dp_hi++;
      end else begin
        checks++;
        if (dec_cat[7] !== 1'b1) begin failures++; $display("FAIL dp_other idx=%0d got=%b want=1", idx, dec_cat[7]); end
      end
    end
`ifdef COLON_DP_EN
    checks++;
    if (dp_lo == 0 || dp_hi == 0) begin
      failures++; $display("FAIL dp_flash lit=%0d dark=%0d want both >0", dp_lo, dp_hi);
    end
`else
    checks++;
    if (dp_lo != 0) begin failures++; $display("FAIL dp_off lit=%0d want=0", dp_lo); end
`endif
    modo_ajuste = 2'b01;
    for (int i = 0; i < 48; i++) begin
      run_cycle(e, idx);
      checks++;
      if ({an, dec_cat} !== {e.an, e.cat}) begin
        failures++; $display("FAIL dp_adj_sb idx=%0d got=%h/%h want=%h/%h", idx, an, dec_cat, e.an, e.cat);
      end
      if (idx == 2 || idx == 4) begin
        checks++;
`ifdef COLON_DP_EN
        if (dec_cat[7] !== 1'b0) begin failures++; $display("FAIL dp_steady idx=%0d got=%b want=0", idx, dec_cat[7]); end
`else
        if (dec_cat[7] !== 1'b1) begin failures++; $display("FAIL dp_steady idx=%0d got=%b want=1", idx, dec_cat[7]); end
`endif
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_blink();
    test_dash();
    test_step();
    test_reset_mid();
    test_dp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
